// File: rtl/instr_fetch.sv
// Instruction fetch unit: on Start, reads instruction ROM at PC, latches the word into IR,
// then emits a one-cycle Done/Prox pair so R7 advances before the next fetch can start.
module instr_fetch #(
  parameter int n       = 16,
  parameter int MEM_LAT = 1
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Start,
  input  logic         Flush,
  input  logic [n-1:0] PC,
  input  logic [n-1:0] MemData,
  output logic [n-1:0] MemAddr,
  output logic         MemRd,
  output logic [n-1:0] IR,
  output logic         Done,
  output logic         Prox,
  output logic         Busy,
  output logic [1:0]   DbgState
);

  // Handshake: Start is a request accepted only when Busy=0 (IDLE); requests while
  // Busy=1 are dropped, never queued. Done/Prox is the single-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [1:0]     cnt, cnt_nx;
  logic [n-1:0]   addr_nx, ir_nx;
  logic           rd_nx, done_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = MemAddr;
    ir_nx    = IR;
    rd_nx    = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start && !Flush) begin
          addr_nx  = PC;
          rd_nx    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (Flush) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = 2'(MEM_LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (Flush) begin
          state_nx = IDLE;
        end else if (cnt != 2'd0) begin
          cnt_nx = cnt - 2'd1;
        end else begin
          ir_nx    = MemData;
          done_nx  = 1'b1;
          state_nx = DONE;
        end
      end
      // DONE ignores Start so the next fetch sees the PC already advanced by Prox.
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      MemAddr <= '0;
      MemRd   <= 1'b0;
      IR      <= '0;
      Done    <= 1'b0;
      Prox    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      MemAddr <= addr_nx;
      MemRd   <= rd_nx;
      IR      <= ir_nx;
      Done    <= done_nx;
      Prox    <= done_nx;
    end
  end

  assign Busy     = (state != IDLE);
  assign DbgState = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (ROM latency 1 and 3), each with its own
// R7 model that increments on Prox and a pipelined ROM model matching the latency.
module tb_instr_fetch;

  logic        clock;
  logic        clear;
  logic        start1, flush1, start3, flush3;
  logic [15:0] pc1, pc3, pc1_val, pc3_val;
  logic        pc1_ld, pc3_ld;
  logic [15:0] md1, md3, addr1, addr3, ir1, ir3;
  logic        rd1, rd3, done1, done3, prox1, prox3, busy1, busy3;
  logic [1:0]  st1, st3;

  logic [15:0] rom [0:65535];
  logic [15:0] p1;
  logic [15:0] p3 [0:2];

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch #(.n(16), .MEM_LAT(1)) u1 (
    .Clock(clock), .Clear(clear), .Start(start1), .Flush(flush1), .PC(pc1),
    .MemData(md1), .MemAddr(addr1), .MemRd(rd1), .IR(ir1), .Done(done1),
    .Prox(prox1), .Busy(busy1), .DbgState(st1)
  );

  instr_fetch #(.n(16), .MEM_LAT(3)) u3 (
    .Clock(clock), .Clear(clear), .Start(start3), .Flush(flush3), .PC(pc3),
    .MemData(md3), .MemAddr(addr3), .MemRd(rd3), .IR(ir3), .Done(done3),
    .Prox(prox3), .Busy(busy3), .DbgState(st3)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ROM: data for an address sampled at edge k is visible after edge k+MEM_LAT-1
  always @(posedge clock) begin
    p1    <= rom[addr1];
    p3[0] <= rom[addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign md1 = p1;
  assign md3 = p3[2];

  // R7 models
  always @(posedge clock) begin
    if (pc1_ld) pc1 <= pc1_val;
    else if (prox1) pc1 <= pc1 + 16'd1;
    if (pc3_ld) pc3 <= pc3_val;
    else if (prox3) pc3 <= pc3 + 16'd1;
  end

  // driver tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic load_pc1(input logic [15:0] v);
    pc1_ld = 1'b1; pc1_val = v;
    step();
    pc1_ld = 1'b0;
  endtask

  task automatic load_pc3(input logic [15:0] v);
    pc3_ld = 1'b1; pc3_val = v;
    step();
    pc3_ld = 1'b0;
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  task automatic pulse_start3();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1;
    start1 = 1'b0; flush1 = 1'b0; start3 = 1'b0; flush3 = 1'b0;
    pc1_ld = 1'b0; pc3_ld = 1'b0; pc1_val = 16'h0; pc3_val = 16'h0;
    for (int i = 0; i < 65536; i++) rom[i] = 16'(i) ^ 16'hC3A5;

    // reset state
    step(); step();
    chk("rst_addr", addr1, 16'h0);
    chk("rst_rd", rd1, 1'b0);
    chk("rst_ir", ir1, 16'h0);
    chk("rst_done", done1, 1'b0);
    chk("rst_prox", prox1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_state", st1, 2'd0);
    chk("rst_busy3", busy3, 1'b0);
    clear = 1'b0;

    // single fetch, latency 1
    rom[16'h0005] = 16'hA3C1;
    load_pc1(16'h0005);
    pulse_start1();
    chk("b_addr", addr1, 16'h0005);
    chk("b_rd", rd1, 1'b1);
    chk("b_busy", busy1, 1'b1);
    step();
    chk("b_rd_e1", rd1, 1'b0);
    chk("b_done_e1", done1, 1'b0);
    step();
    chk("b_ir", ir1, 16'hA3C1);
    chk("b_done", done1, 1'b1);
    chk("b_prox", prox1, 1'b1);
    step();
    chk("b_done_e3", done1, 1'b0);
    chk("b_prox_e3", prox1, 1'b0);
    chk("b_busy_e3", busy1, 1'b0);
    chk("b_ir_hold", ir1, 16'hA3C1);

    // back-to-back with Start held
    rom[16'h0005] = 16'h1111;
    rom[16'h0006] = 16'h2222;
    load_pc1(16'h0005);
    start1 = 1'b1;
    step();
    chk("c_addr0", addr1, 16'h0005);
    chk("c_rd0", rd1, 1'b1);
    step(); step();
    chk("c_done0", done1, 1'b1);
    chk("c_ir0", ir1, 16'h1111);
    step();
    chk("c_done_e3", done1, 1'b0);
    step();
    chk("c_addr1", addr1, 16'h0006);
    chk("c_rd1", rd1, 1'b1);
    step();
    chk("c_done_e5", done1, 1'b0);
    step();
    chk("c_done1", done1, 1'b1);
    chk("c_ir1", ir1, 16'h2222);
    start1 = 1'b0;
    step();
    chk("c_done_e7", done1, 1'b0);
    chk("c_busy_e7", busy1, 1'b0);
    step();
    chk("c_rd_e8", rd1, 1'b0);

    // Start with Flush in IDLE
    start1 = 1'b1; flush1 = 1'b1;
    step();
    chk("d_rd", rd1, 1'b0);
    chk("d_busy", busy1, 1'b0);
    step();
    chk("d_rd2", rd1, 1'b0);
    start1 = 1'b0; flush1 = 1'b0;

    // Start during DONE ignored; next fetch uses incremented PC (R7 = 7 here)
    rom[16'h0007] = 16'h7777;
    rom[16'h0008] = 16'h8888;
    pulse_start1();
    chk("d_addr7", addr1, 16'h0007);
    step(); step();
    chk("d_done", done1, 1'b1);
    chk("d_ir7", ir1, 16'h7777);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("d_ign_rd", rd1, 1'b0);
    chk("d_ign_busy", busy1, 1'b0);
    pulse_start1();
    chk("d_addr8", addr1, 16'h0008);
    chk("d_rd8", rd1, 1'b1);
    step(); step();
    chk("d_ir8", ir1, 16'h8888);
    step();
    chk("d_done_off", done1, 1'b0);

    // wrap-around
    rom[16'hFFFF] = 16'hBEEF;
    rom[16'h0000] = 16'h0C0D;
    load_pc1(16'hFFFF);
    pulse_start1();
    chk("e_addr", addr1, 16'hFFFF);
    step(); step();
    chk("e_ir", ir1, 16'hBEEF);
    chk("e_prox", prox1, 1'b1);
    step();
    chk("e_prox_off", prox1, 1'b0);
    pulse_start1();
    chk("e_addr0", addr1, 16'h0000);
    step(); step();
    chk("e_ir0", ir1, 16'h0C0D);
    chk("e_done0", done1, 1'b1);
    step();
    chk("e_done0_off", done1, 1'b0);

    // latency 3 fetch: ROM[5] = 0x1111
    load_pc3(16'h0005);
    pulse_start3();
    chk("f_addr", addr3, 16'h0005);
    chk("f_rd", rd3, 1'b1);
    step();
    chk("f_state_wait", st3, 2'd2);
    step(); step();
    chk("f_done_e3", done3, 1'b0);
    chk("f_busy_e3", busy3, 1'b1);
    step();
    chk("f_done", done3, 1'b1);
    chk("f_prox", prox3, 1'b1);
    chk("f_ir", ir3, 16'h1111);
    step();
    chk("f_done_off", done3, 1'b0);

    // Flush one cycle into WAIT
    pulse_start3();
    step(); step();
    flush3 = 1'b1;
    step();
    flush3 = 1'b0;
    chk("g_busy", busy3, 1'b0);
    chk("g_state", st3, 2'd0);
    chk("g_ir", ir3, 16'h1111);
    for (int k = 0; k < 3; k++) begin
      chk("g_done", done3, 1'b0);
      chk("g_prox", prox3, 1'b0);
      step();
    end

    // asynchronous Clear mid-cycle in WAIT; PC unchanged by the flushed fetch
    pulse_start3();
    chk("h_addr6", addr3, 16'h0006);
    step();
    #2 clear = 1'b1;
    #1;
    chk("h_addr", addr3, 16'h0);
    chk("h_rd", rd3, 1'b0);
    chk("h_ir", ir3, 16'h0);
    chk("h_done", done3, 1'b0);
    chk("h_prox", prox3, 1'b0);
    chk("h_busy", busy3, 1'b0);
    chk("h_state", st3, 2'd0);
    step();
    clear = 1'b0;
    step();
    chk("h_idle_done", done3, 1'b0);
    pulse_start3();
    chk("h_re_addr", addr3, 16'h0006);
    step(); step(); step();
    step();
    chk("h_re_ir", ir3, 16'h2222);
    chk("h_re_done", done3, 1'b1);
    step();
    chk("h_re_done_off", done3, 1'b0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit of the simple processor; consumes the R7 program-counter value and reads instruction memory at that address.
- On a control-unit request it issues one synchronous-ROM read and latches the returned word into IR.
- It then signals completion and emits the one-cycle Prox pulse that advances R7.
- Sits between the R7 counter, instruction ROM and the control FSM.

Parameters:
- n, 16, address/instruction word width.
- MEM_LAT, 1, ROM read latency in clock edges after the address-sampling edge (legal 1..4).

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  reset, asynchronous, active-high.
- Start  in  1  fetch request from control FSM, sampled only in IDLE.
- Flush  in  1  synchronous abort of an in-flight fetch (jump/branch).
- PC  in  n  current R7 value.
- MemData  in  n  ROM read data.
- MemAddr  out  n  ROM address, registered.
- MemRd  out  1  ROM read strobe, registered.
- IR  out  n  instruction register.
- Done  out  1  one-cycle pulse: IR holds the new instruction.
- Prox  out  1  one-cycle increment pulse to R7, coincident with Done.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Clear=1 forces immediately, independent of Clock: state IDLE, MemAddr=0, MemRd=0, IR=0, Done=0, Prox=0, Busy=0, wait counter=0. Clear mid-fetch abandons the fetch and leaves no pulse pending.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Flush=1: stay in IDLE.
  - Start=1 and Flush=0: next edge sets MemAddr<=PC, MemRd<=1, state ISSUE.
  - Otherwise: stay in IDLE, MemRd=0.
- ISSUE (one cycle; ROM samples MemAddr at the exiting edge):
  - Next edge sets MemRd<=0, counter<=MEM_LAT-1, state WAIT.
  - Flush=1: next edge sets MemRd<=0, state IDLE.
- WAIT:
  - Flush=1: state IDLE; IR unchanged; no Done/Prox.
  - Counter≠0: decrement and stay in WAIT.
  - Counter=0: IR<=MemData, Done<=1, Prox<=1, state DONE.
- DONE (exactly one cycle):
  - Done=1 and Prox=1 during this cycle; R7 increments at the exiting edge.
  - Next edge sets Done<=0, Prox<=0, state IDLE.
  - Start and Flush are ignored in DONE. This guarantees the next fetch samples the incremented PC.
- Latency: Start sampled at edge e0 → MemRd high in cycle e0..e1 → IR updated at edge e(MEM_LAT+1) → Done/Prox high for cycle e(MEM_LAT+1)..e(MEM_LAT+2).
- Minimum fetch-to-fetch period is MEM_LAT+3 cycles (Start held high continuously).
- MemAddr holds its last value outside ISSUE and changes only on IDLE→ISSUE.
- IR holds its value until the next completed fetch; it is never altered by Flush.
- Start while Busy=1 is ignored; no request is queued.
- Flush outside ISSUE/WAIT has no effect.
- PC wrap-around (0xFFFF) is the counter's concern; this block passes PC through with no arithmetic.

Test Plan:
- Reset: assert Clear asynchronously mid-cycle during WAIT → all outputs 0 within the same cycle, state IDLE; a Start after release fetches normally.
- Single fetch, MEM_LAT=1: PC=0x0005, ROM[5]=0xA3C1, Start pulsed at e0 → MemAddr=0x0005 and MemRd=1 after e0; IR=0xA3C1, Done=Prox=1 after e2, both 0 after e3.
- Back-to-back fetches: Start held high, R7 model increments on Prox, ROM[5]=0x1111, ROM[6]=0x2222 → IR=0x1111 then 0x2222; second MemAddr=0x0006; Done pulses 4 cycles apart.
- Flush in WAIT, MEM_LAT=3: Start, then Flush one cycle into WAIT → returns to IDLE; IR keeps its prior 0x1111; Done and Prox never assert; PC unchanged.
- Flush and Start together in IDLE → no fetch, MemRd stays 0. Start during DONE → ignored, and the next Start fetches from the incremented PC.
- Wrap-around: PC=0xFFFF, ROM[0xFFFF]=0xBEEF → IR=0xBEEF, Prox pulses once; next fetch with PC=0x0000 reads ROM[0].
